// File: rtl/axi_lite_data_mem.sv
// AXI4-Lite slave data memory: word array with byte-lane strobes, base/depth
// decode, SLVERR on out-of-range accesses, independent write and read FSMs.
module axi_lite_data_mem #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready
);
  localparam int NB    = DATA_W / 8;
  localparam int SH    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_VALID} r_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // Address must not wrap below BASE_ADDR, hence the explicit lower-bound test.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> SH) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> SH;
    return off[IDX_W-1:0];
  endfunction

  // ---------------- write channel ----------------
  w_state_t          w_state, w_next;
  logic [ADDR_W-1:0] aw_q;
  logic [DATA_W-1:0] wd_q;
  logic [NB-1:0]     ws_q;
  logic              commit;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [NB-1:0]     c_strb;

  always_comb begin
    w_next    = w_state;
    commit    = 1'b0;
    c_addr    = s_awaddr;
    c_data    = s_wdata;
    c_strb    = s_wstrb;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_awready = 1'b1;
        s_wready  = 1'b1;
        if (s_awvalid && s_wvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (s_awvalid) w_next = W_HAVE_A;
        else if (s_wvalid)      w_next = W_HAVE_D;
      end
      W_HAVE_A: begin
        s_wready = 1'b1;
        c_addr   = aw_q;
        if (s_wvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_HAVE_D: begin
        s_awready = 1'b1;
        c_data    = wd_q;
        c_strb    = ws_q;
        if (s_awvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      aw_q    <= '0;
      wd_q    <= '0;
      ws_q    <= '0;
      s_bresp <= OKAY;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && s_awvalid && !s_wvalid) aw_q <= s_awaddr;
      if (w_state == W_IDLE && s_wvalid && !s_awvalid) begin
        wd_q <= s_wdata;
        ws_q <= s_wstrb;
      end
      if (commit) s_bresp <= in_range(c_addr) ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (commit && in_range(c_addr)) begin
      for (int b = 0; b < NB; b++)
        if (c_strb[b]) mem[word_idx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  // mem is sampled before this edge's commit lands, so a same-edge read sees old data.
  r_state_t r_state, r_next;

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) r_next = R_VALID;
      end
      R_VALID: begin
        s_rvalid = 1'b1;
        if (s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      s_rdata <= '0;
      s_rresp <= OKAY;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && s_arvalid) begin
        if (in_range(s_araddr)) begin
          s_rdata <= mem[word_idx(s_araddr)];
          s_rresp <= OKAY;
        end else begin
          s_rdata <= '0;
          s_rresp <= SLVERR;
        end
      end
    end
  end

endmodule

// File: doc/axi_lite_data_mem.md
Name: axi_lite_data_mem

Overview:
- Parametrised data memory with an AXI4-Lite slave interface.
- Replaces the single-cycle core's flat data array; sits behind the core's load/store AXI4-Lite master.
- Adds a configurable base address and depth, byte-lane write strobes, and SLVERR on out-of-range accesses.
- Write and read channels have independent state machines and may run concurrently.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; must be 32 or 64.
- DEPTH, 256, number of DATA_W words; must be ≥2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DATA_W/8.
- RESET_VAL, 0, value loaded into every word on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  DATA_W  write data.
- s_wstrb  in  DATA_W/8  byte-lane enables.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  ADDR_W  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.

Behaviour:
- Reset: rst_n, asynchronous, active-low.
  - Reset forces both FSMs to idle and loads every memory word with RESET_VAL.
  - Output values during reset: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0.
  - Reset asserted mid-transaction discards the transaction: no partial write, no response.
- Address decode:
  - off = addr − BASE_ADDR; idx = off >> log2(DATA_W/8).
  - In range iff addr ≥ BASE_ADDR and idx < DEPTH. Low address bits below the word boundary are ignored.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - W_IDLE: s_awready=1, s_wready=1.
    - AW and W handshakes in the same cycle → commit, go to W_RESP.
    - AW handshake only → latch address, go to W_HAVE_A.
    - W handshake only → latch data and strobe, go to W_HAVE_D.
  - W_HAVE_A: s_awready=0, s_wready=1. W handshake → commit, go to W_RESP.
  - W_HAVE_D: s_wready=0, s_awready=1. AW handshake → commit, go to W_RESP.
  - Commit happens on the clock edge completing the second handshake.
    - In range: each byte lane with wstrb[b]=1 is written; other lanes are unchanged.
    - Out of range: memory is untouched and bresp=SLVERR.
  - W_RESP: both readies 0, s_bvalid=1, s_bresp held stable until s_bready. On the s_bready edge return to W_IDLE.
  - s_bvalid rises exactly 1 cycle after the completing handshake.
- Read FSM states: R_IDLE, R_VALID.
  - R_IDLE: s_arready=1. On AR handshake, register s_rdata/s_rresp and go to R_VALID.
    - In range: s_rdata = mem[idx], s_rresp = OKAY.
    - Out of range: s_rdata = 0, s_rresp = SLVERR.
  - R_VALID: s_arready=0, s_rvalid=1, s_rdata/s_rresp held stable until s_rready; then return to R_IDLE.
  - Read latency: s_rvalid rises 1 cycle after the AR handshake.
  - Maximum throughput: one read every 2 cycles; one write every 2 cycles when AW and W arrive together.
- Simultaneous events:
  - An AR handshake on the same edge as a write commit to the same word returns the pre-write data.
  - A read accepted on any later edge returns the new data.
- wstrb=0 with an in-range address: no memory change, bresp=OKAY.
- s_*ready never depends combinationally on s_*valid.

Test Plan:
- Reset with DEPTH=256, RESET_VAL=5 → read at BASE_ADDR+0x3FC returns 5, OKAY, s_rvalid 1 cycle after AR.
- AW and W together: addr 0x10, data 0xDEADBEEF, wstrb 4'b1111 → bvalid next cycle, OKAY. Then wstrb 4'b0010 with data 0x0000AA00 → read 0x10 returns 0xDEADAAEF.
- W presented 3 cycles before AW, with s_bready held low 4 cycles → commit only on the AW edge; bvalid and bresp stable throughout; no new AW accepted until the B handshake.
- Write to addr 0x400 (idx=256) → SLVERR, memory unchanged. Read of 0x400 → rdata 0, SLVERR. Address below BASE_ADDR (BASE=0x1000, addr 0xFFC) → SLVERR.
- Read of addr 0x20 on the same edge as a write commit of 0x12345678 to 0x20 → returns the old value. Immediate re-read → returns 0x12345678.
- rst_n pulsed low while in W_HAVE_A and R_VALID → s_bvalid=s_rvalid=0 immediately, all readies=1, memory reads RESET_VAL.
